apb_req_scheduler: RTL and testbench

- Shares the single APB master engine between NREQ independent requesters.
- Round-robin arbitration; one transfer in flight at a time.
- Drives the engine's command interface (transfer, 33-bit {write,addr}, 32-bit wdata) and waits for its completion pulse.
- Returns read data or write status to the winning requester through a valid/ready response channel, with a completion timeout.

---
 rtl/apb_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/apb_req_scheduler.sv | 163 ++++++++++++++++
 tb/tb_apb_req_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_sched_pkg.sv
// Shared definitions for the APB request scheduler.
//   state_t : scheduler FSM encoding (ARB / BUSY / RESP)
//   CMD_W   : width of a {write, addr} command word
//   DATA_W  : APB data width
//   WR_BIT  : position of the write flag inside a command word
package apb_sched_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int CMD_W  = 33;
    localparam int DATA_W = 32;
    localparam int WR_BIT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req    : per-requester request vector
//   i_rr_ptr : highest-priority index for this decision
//   o_gnt    : one-hot grant (all zero when nothing requests)
//   o_gnt_id : encoded index of the granted requester
//   o_any    : at least one request is present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_rr_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_any
);

    always_comb begin
        logic [IDW:0]   w_sum;
        logic [IDW-1:0] w_idx;
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        // Scan from the pointer upward; NREQ need not be a power of two,
        // so the wrap is an explicit compare-and-subtract.
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/apb_req_scheduler.sv
// Shares one APB master engine between NREQ requesters.
//   Pclk, Presetn        : clock, asynchronous active-low reset
//   req_valid/addr/wdata : per-requester commands ({write, addr}, wdata)
//   req_ready            : one-hot accept, asserted only in the accept cycle
//   rsp_*                : response channel (valid/ready), id, read data, timeout flag
//   m_transfer/addr/wdata: command to the APB master engine, held while BUSY
//   m_done, m_rdata      : single-cycle completion pulse and read data from the engine
//   busy                 : scheduler is not idle in ARB
module apb_req_scheduler
    import apb_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                 Pclk,
    input  logic                 Presetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*33-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 m_transfer,
    output logic [32:0]          m_addr,
    output logic [31:0]          m_wdata,
    input  logic                 m_done,
    input  logic [31:0]          m_rdata,
    output logic                 busy
);

    state_t              r_state;
    state_t              w_next;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_gnt_id;
    logic [CMD_W-1:0]    r_cmd;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [TW-1:0]       r_cnt;

    logic [NREQ-1:0]     w_gnt;
    logic [IDW-1:0]      w_gnt_id;
    logic                w_any;
    logic [CMD_W-1:0]    w_sel_cmd;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_accept;
    logic                w_fin;
    logic                w_hs;
    logic                w_to;
    logic [IDW-1:0]      w_ptr_next;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    // Command mux driven by the one-hot grant.
    always_comb begin
        w_sel_cmd   = '0;
        w_sel_wdata = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_gnt[k]) begin
                w_sel_cmd   = req_addr[k*CMD_W +: CMD_W];
                w_sel_wdata = req_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Counter value before increment equals elapsed BUSY cycles minus one,
    // so the transfer is abandoned in the TIMEOUT-th BUSY cycle.
    assign w_to       = (r_cnt >= TW'(TIMEOUT - 1));
    assign w_ptr_next = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_fin     = 1'b0;
        w_hs      = 1'b0;
        req_ready = '0;
        case (r_state)
            ARB: begin
                if (w_any) begin
                    // Gated by reset so no accept is ever shown while held in reset.
                    req_ready = Presetn ? w_gnt : '0;
                    w_accept  = 1'b1;
                    w_next    = BUSY;
                end
            end
            BUSY: begin
                if (m_done || w_to) begin
                    w_fin  = 1'b1;
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_hs   = 1'b1;
                    w_next = ARB;
                end
            end
            default: w_next = ARB;
        endcase
    end

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_cmd    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_gnt_id <= w_gnt_id;
                r_cmd    <= w_sel_cmd;
                r_wdata  <= w_sel_wdata;
            end
            if (r_state == BUSY && r_cnt != '1) begin
                r_cnt <= r_cnt + TW'(1);
            end
            if (w_fin) begin
                // m_done has priority over a simultaneous timeout.
                r_err   <= !m_done;
                r_rdata <= (m_done && !r_cmd[WR_BIT]) ? m_rdata : '0;
            end
            if (w_hs) begin
                r_rr_ptr <= w_ptr_next;
                r_cnt    <= '0;
            end
        end
    end

    assign m_transfer = (r_state == BUSY);
    assign rsp_valid  = (r_state == RESP);
    assign busy       = (r_state != ARB);
    assign m_addr     = r_cmd;
    assign m_wdata    = r_wdata;
    assign rsp_id     = r_gnt_id;
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Directed bench for apb_req_scheduler (NREQ=4, TIMEOUT=8).
module tb_apb_req_scheduler;

    logic          Pclk;
    logic          Presetn;
    logic [3:0]    req_valid;
    logic [131:0]  req_addr;
    logic [127:0]  req_wdata;
    logic [3:0]    req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          m_transfer;
    logic [32:0]   m_addr;
    logic [31:0]   m_wdata;
    logic          m_done;
    logic [31:0]   m_rdata;
    logic          busy;

    apb_req_scheduler #(
        .NREQ    (4),
        .IDW     (2),
        .TIMEOUT (8),
        .TW      (8)
    ) dut (
        .Pclk       (Pclk),
        .Presetn    (Presetn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_transfer (m_transfer),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_done     (m_done),
        .m_rdata    (m_rdata),
        .busy       (busy)
    );

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;

    typedef struct {
        logic [3:0]  rv;
        logic        rr;
        logic        md;
        logic [31:0] mrd;
        logic [3:0]  e_rdy;
        logic        e_mt;
        logic [32:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_rv;
        logic [1:0]  e_id;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    logic [32:0] addr_c [4];
    logic [31:0] wd_c   [4];
    vec_t        tbl[$];
    int          total = 0;
    int          bad   = 0;
    int          vi    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic rr, input logic md,
                                input logic [31:0] mrd, input logic [3:0] e_rdy,
                                input logic e_mt, input logic [32:0] e_maddr,
                                input logic [31:0] e_mwd, input logic e_rv,
                                input logic [1:0] e_id, input logic [31:0] e_rd,
                                input logic e_err);
        vec_t v;
        v.rv = rv; v.rr = rr; v.md = md; v.mrd = mrd; v.e_rdy = e_rdy;
        v.e_mt = e_mt; v.e_maddr = e_maddr; v.e_mwd = e_mwd; v.e_rv = e_rv;
        v.e_id = e_id; v.e_rd = e_rd; v.e_err = e_err;
        return v;
    endfunction

    // ARB-state cycle (accept or idle)
    function automatic vec_t arb(input logic [3:0] rv, input logic rr, input logic [3:0] e_rdy);
        return mk(rv, rr, 1'b0, 32'h0, e_rdy, 1'b0, 33'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
    endfunction

    // BUSY-state cycle serving requester g
    function automatic vec_t bsy(input logic [3:0] rv, input logic md, input logic [31:0] mrd,
                                 input int g);
        return mk(rv, 1'b0, md, mrd, 4'b0, 1'b1, addr_c[g], wd_c[g], 1'b0, 2'd0, 32'h0, 1'b0);
    endfunction

    // RESP-state cycle
    function automatic vec_t rsp(input logic [3:0] rv, input logic rr, input logic md,
                                 input logic [31:0] mrd, input logic [1:0] id,
                                 input logic [31:0] rd, input logic err);
        return mk(rv, rr, md, mrd, 4'b0, 1'b0, 33'h0, 32'h0, 1'b1, id, rd, err);
    endfunction

    // Entered at posedge+1; drives inputs, checks at negedge, returns at next posedge+1.
    task automatic apply(input vec_t v);
        req_valid = v.rv;
        rsp_ready = v.rr;
        m_done    = v.md;
        m_rdata   = v.mrd;
        @(negedge Pclk);
        chk($sformatf("v%0d.req_ready", vi), 64'(req_ready), 64'(v.e_rdy));
        chk($sformatf("v%0d.m_transfer", vi), 64'(m_transfer), 64'(v.e_mt));
        chk($sformatf("v%0d.rsp_valid", vi), 64'(rsp_valid), 64'(v.e_rv));
        chk($sformatf("v%0d.busy", vi), 64'(busy), 64'(v.e_mt | v.e_rv));
        if (v.e_mt) begin
            chk($sformatf("v%0d.m_addr", vi), 64'(m_addr), 64'(v.e_maddr));
            chk($sformatf("v%0d.m_wdata", vi), 64'(m_wdata), 64'(v.e_mwd));
        end
        if (v.e_rv) begin
            chk($sformatf("v%0d.rsp_id", vi), 64'(rsp_id), 64'(v.e_id));
            chk($sformatf("v%0d.rsp_rdata", vi), 64'(rsp_rdata), 64'(v.e_rd));
            chk($sformatf("v%0d.rsp_err", vi), 64'(rsp_err), 64'(v.e_err));
        end
        vi++;
        @(posedge Pclk);
        #1;
    endtask

    initial begin
        logic [3:0]  oh;
        logic [31:0] rd;

        addr_c[0] = {1'b1, 32'h0000_0010}; wd_c[0] = 32'h1234_5678;
        addr_c[1] = {1'b0, 32'h0000_0040}; wd_c[1] = 32'h0000_1111;
        addr_c[2] = {1'b0, 32'h0000_0200}; wd_c[2] = 32'h0000_2222;
        addr_c[3] = {1'b1, 32'h0000_0300}; wd_c[3] = 32'hA5A5_0003;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*33 +: 33]  = addr_c[i];
            req_wdata[i*32 +: 32] = wd_c[i];
        end

        // Round robin, all four requesting: grants 0,1,2,3,0 (rr_ptr ends at 1)
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << (n % 4);
            rd = addr_c[n % 4][32] ? 32'h0 : (32'h1000_0000 | 32'(n % 4));
            tbl.push_back(arb(4'hF, 1'b1, oh));
            tbl.push_back(bsy(4'hF, 1'b1, 32'h1000_0000 | 32'(n % 4), n % 4));
            tbl.push_back(rsp(4'hF, 1'b1, 1'b0, 32'h0, 2'(n % 4), rd, 1'b0));
        end
        // Single read by requester 1, m_done in third transfer cycle (rr_ptr -> 2)
        tbl.push_back(arb(4'b0010, 1'b0, 4'b0010));
        tbl.push_back(bsy(4'b0000, 1'b0, 32'h0, 1));
        tbl.push_back(bsy(4'b0000, 1'b0, 32'h0, 1));
        tbl.push_back(bsy(4'b0000, 1'b1, 32'hDEAD_BEEF, 1));
        tbl.push_back(rsp(4'b0000, 1'b1, 1'b0, 32'h0, 2'd1, 32'hDEAD_BEEF, 1'b0));
        tbl.push_back(arb(4'b0000, 1'b0, 4'b0000));
        // Write by requester 0 (pointer wraps 2->3->0); read data discarded (rr_ptr -> 1)
        tbl.push_back(arb(4'b0001, 1'b0, 4'b0001));
        tbl.push_back(bsy(4'b0000, 1'b1, 32'hFFFF_FFFF, 0));
        tbl.push_back(rsp(4'b0000, 1'b1, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0));
        // Backpressure: response to requester 2 held 5 cycles with others requesting
        tbl.push_back(arb(4'b0100, 1'b0, 4'b0100));
        tbl.push_back(bsy(4'b1011, 1'b1, 32'hCAFE_0002, 2));
        for (int n = 0; n < 5; n++)
            tbl.push_back(rsp(4'b1011, 1'b0, 1'b0, 32'h0, 2'd2, 32'hCAFE_0002, 1'b0));
        tbl.push_back(rsp(4'b1011, 1'b1, 1'b0, 32'h0, 2'd2, 32'hCAFE_0002, 1'b0));
        tbl.push_back(arb(4'b1011, 1'b0, 4'b1000));

        Presetn   = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        m_done    = 1'b0;
        m_rdata   = 32'h0;
        repeat (2) @(posedge Pclk);
        @(negedge Pclk);
        chk("rst.req_ready",  64'(req_ready),  64'h0);
        chk("rst.m_transfer", 64'(m_transfer), 64'h0);
        chk("rst.rsp_valid",  64'(rsp_valid),  64'h0);
        chk("rst.busy",       64'(busy),       64'h0);
        chk("rst.m_addr",     64'(m_addr),     64'h0);
        chk("rst.m_wdata",    64'(m_wdata),    64'h0);
        chk("rst.rsp_id",     64'(rsp_id),     64'h0);
        chk("rst.rsp_rdata",  64'(rsp_rdata),  64'h0);
        chk("rst.rsp_err",    64'(rsp_err),    64'h0);
        req_valid = 4'h0;
        @(posedge Pclk);
        #1;
        Presetn = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Timeout: requester 3 write, engine silent for 8 cycles; stray m_done in RESP ignored
        for (int n = 0; n < 8; n++) apply(bsy(4'b0011, 1'b0, 32'h0, 3));
        apply(rsp(4'b0011, 1'b0, 1'b1, 32'h0000_1234, 2'd3, 32'h0, 1'b1));
        apply(rsp(4'b0011, 1'b1, 1'b0, 32'h0, 2'd3, 32'h0, 1'b1));
        // Next requester (0) served normally after the timeout (rr_ptr -> 1)
        apply(arb(4'b0011, 1'b0, 4'b0001));
        apply(bsy(4'b0010, 1'b1, 32'h0000_0055, 0));
        apply(rsp(4'b0010, 1'b1, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0));

        // m_done in the same cycle the counter reaches TIMEOUT: completion wins
        apply(arb(4'b0010, 1'b0, 4'b0010));
        for (int n = 0; n < 7; n++) apply(bsy(4'b0000, 1'b0, 32'h0, 1));
        apply(bsy(4'b0000, 1'b1, 32'hBEEF_0008, 1));
        apply(rsp(4'b0000, 1'b1, 1'b0, 32'h0, 2'd1, 32'hBEEF_0008, 1'b0));

        // Reset in the middle of a transfer for requester 2
        apply(arb(4'b0100, 1'b0, 4'b0100));
        apply(bsy(4'b0100, 1'b0, 32'h0, 2));
        Presetn = 1'b0;
        #1;
        chk("midrst.m_transfer", 64'(m_transfer), 64'h0);
        chk("midrst.busy",       64'(busy),       64'h0);
        chk("midrst.rsp_valid",  64'(rsp_valid),  64'h0);
        chk("midrst.req_ready",  64'(req_ready),  64'h0);
        @(posedge Pclk);
        #1;
        Presetn = 1'b1;
        apply(arb(4'b0000, 1'b0, 4'b0000));
        apply(mk(4'b0000, 1'b1, 1'b1, 32'h0000_FFFF, 4'b0, 1'b0, 33'h0, 32'h0,
                 1'b0, 2'd0, 32'h0, 1'b0));
        apply(arb(4'b0000, 1'b1, 4'b0000));
        // rr_ptr cleared: requester 0 wins with everyone requesting
        apply(arb(4'hF, 1'b1, 4'b0001));
        apply(bsy(4'hF, 1'b1, 32'h0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
